// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a valid/ready stream through a 3-word skid buffer.
// Optional transfer counter enabled by defining FIFO_STREAM_READER_COUNT_EN.
module fifo_stream_reader #(
    parameter int data_word_size_g = 8,
    parameter int count_width_g    = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clk_en_i,
    input  logic                        fifo_r_empty_i,
    input  logic [data_word_size_g-1:0] fifo_r_data_i,
    output logic                        fifo_r_en_o,
    output logic [data_word_size_g-1:0] m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [count_width_g-1:0]    m_count_o
);

    logic [data_word_size_g-1:0] buf_q [3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [1:0] occ;
    logic       inflight;
    logic       capture;
    logic       transfer;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued when the word it returns is guaranteed a free slot.
    assign fifo_r_en_o = ~rst_i & clk_en_i & ~fifo_r_empty_i &
                         (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    assign m_valid_o   = (occ != 2'd0);
    assign m_data_o    = m_valid_o ? buf_q[rd_ptr] : '0;
    assign capture     = clk_en_i & inflight;
    assign transfer    = clk_en_i & m_valid_o & m_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else if (clk_en_i) begin
            inflight <= fifo_r_en_o;
            if (capture) begin
                buf_q[wr_ptr] <= fifo_r_data_i;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (transfer) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({capture, transfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [count_width_g-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (transfer) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign m_count_o = count_q;
`else
    assign m_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a registered-read FIFO model.
module tb_fifo_stream_reader;

    logic       clk_i;
    logic       rst_i;
    logic       clk_en_i;
    logic       fifo_r_empty_i;
    logic [7:0] fifo_r_data_i;
    logic       fifo_r_en_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic [3:0] m_count_o;

    int n_compared;
    int n_mismatched;

    logic [7:0] fifo_mem [64];
    int         fifo_wr;
    int         fifo_rd;

    logic [7:0] xfer_log [64];
    int         n_xfer;
    int         n_strobe;

    fifo_stream_reader #(
        .data_word_size_g(8),
        .count_width_g   (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clk_en_i      (clk_en_i),
        .fifo_r_empty_i(fifo_r_empty_i),
        .fifo_r_data_i (fifo_r_data_i),
        .fifo_r_en_o   (fifo_r_en_o),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_count_o     (m_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign fifo_r_empty_i = (fifo_rd == fifo_wr);

    // FIFO with registered read data, and a monitor logging strobes and transfers.
    always @(posedge clk_i) begin
        if (fifo_r_en_o) begin
            fifo_r_data_i <= fifo_mem[fifo_rd];
            fifo_rd       <= fifo_rd + 1;
            n_strobe      <= n_strobe + 1;
        end
        if (!rst_i && clk_en_i && m_valid_o && m_ready_i) begin
            xfer_log[n_xfer] <= m_data_o;
            n_xfer           <= n_xfer + 1;
        end
    end

    function automatic logic [31:0] expCount(input int n);
`ifdef FIFO_STREAM_READER_COUNT_EN
        return n % 16;
`else
        return 0;
`endif
    endfunction

    task automatic applyStimulus(input logic rst, input logic en, input logic rdy);
        rst_i     = rst;
        clk_en_i  = en;
        m_ready_i = rdy;
    endtask

    task automatic pushWord(input logic [7:0] w);
        fifo_mem[fifo_wr] = w;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        logic [7:0] exp_a_data  [6];
        logic       exp_a_valid [6];
        logic       exp_a_ren   [6];
        logic [7:0] exp_e_data  [5];
        logic       exp_e_valid [5];
        int         base_x;
        int         base_s;

        n_compared    = 0;
        n_mismatched  = 0;
        fifo_wr       = 0;
        fifo_rd       = 0;
        n_xfer        = 0;
        n_strobe      = 0;
        fifo_r_data_i = 8'h00;
        exp_a_data    = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        exp_a_valid   = '{0, 0, 1, 1, 1, 0};
        exp_a_ren     = '{1, 1, 1, 0, 0, 0};
        exp_e_data    = '{8'h00, 8'h00, 8'h64, 8'h65, 8'h00};
        exp_e_valid   = '{0, 0, 1, 1, 0};

        $display("[TB] start");
        applyStimulus(1'b1, 1'b1, 1'b1);
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        nextCycle();
        checkOutput("rst_valid", {31'd0, m_valid_o}, 32'd0);
        checkOutput("rst_data", {24'd0, m_data_o}, 32'd0);
        checkOutput("rst_ren", {31'd0, fifo_r_en_o}, 32'd0);
        checkOutput("rst_count", {28'd0, m_count_o}, 32'd0);

        // Three words, ready held high.
        base_x = n_xfer;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("a_ren_c%0d", c), {31'd0, fifo_r_en_o}, {31'd0, exp_a_ren[c]});
            checkOutput($sformatf("a_valid_c%0d", c), {31'd0, m_valid_o}, {31'd0, exp_a_valid[c]});
            checkOutput($sformatf("a_data_c%0d", c), {24'd0, m_data_o}, {24'd0, exp_a_data[c]});
            if (c < 5) nextCycle();
        end
        checkOutput("a_count", {28'd0, m_count_o}, expCount(3));
        checkOutput("a_nxfer", n_xfer - base_x, 32'd3);

        // Five words with a stalled consumer, then drain.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pushWord(8'h41 + 8'(i));
        nextCycle();
        base_s = n_strobe;
        applyStimulus(1'b0, 1'b1, 1'b0);
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6 || c == 7) applyStimulus(1'b0, 1'b0, 1'b0);
            else applyStimulus(1'b0, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("b_ren_c%0d", c), {31'd0, fifo_r_en_o}, (c < 3) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                checkOutput($sformatf("b_hold_valid_c%0d", c), {31'd0, m_valid_o}, 32'd1);
                checkOutput($sformatf("b_hold_data_c%0d", c), {24'd0, m_data_o}, 32'h41);
            end
            nextCycle();
        end
        checkOutput("b_strobes", n_strobe - base_s, 32'd3);
        base_x = n_xfer;
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("b_valid_%0d", c), {31'd0, m_valid_o}, 32'd1);
            checkOutput($sformatf("b_data_%0d", c), {24'd0, m_data_o}, 32'h41 + c);
            nextCycle();
        end
        checkOutput("b_drained", {31'd0, m_valid_o}, 32'd0);
        checkOutput("b_nxfer", n_xfer - base_x, 32'd5);

        // Empty FIFO throughout.
        applyStimulus(1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("c_ren_c%0d", c), {31'd0, fifo_r_en_o}, 32'd0);
            checkOutput($sformatf("c_valid_c%0d", c), {31'd0, m_valid_o}, 32'd0);
            nextCycle();
        end

        // Clock enable toggling every cycle.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) pushWord(8'h51 + 8'(i));
        nextCycle();
        base_x = n_xfer;
        for (int c = 0; c < 14; c++) begin
            applyStimulus(1'b0, (c % 2) == 0, 1'b1);
            #1;
            if ((c % 2) == 1) checkOutput($sformatf("d_ren_off_c%0d", c), {31'd0, fifo_r_en_o}, 32'd0);
            nextCycle();
        end
        checkOutput("d_nxfer", n_xfer - base_x, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("d_order_%0d", i), {24'd0, xfer_log[base_x + i]}, 32'h51 + i);
        end
        checkOutput("d_count", {28'd0, m_count_o}, expCount(4));

        // Reset mid-operation with occ=2 and one read in flight.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) pushWord(8'h61 + 8'(i));
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("e_pre_valid", {31'd0, m_valid_o}, 32'd1);
        checkOutput("e_pre_data", {24'd0, m_data_o}, 32'h61);
        applyStimulus(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("e_rst_valid", {31'd0, m_valid_o}, 32'd0);
        checkOutput("e_rst_data", {24'd0, m_data_o}, 32'd0);
        checkOutput("e_rst_ren", {31'd0, fifo_r_en_o}, 32'd0);
        checkOutput("e_rst_count", {28'd0, m_count_o}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b1);
        #1;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("e_valid_c%0d", c), {31'd0, m_valid_o}, {31'd0, exp_e_valid[c]});
            checkOutput($sformatf("e_data_c%0d", c), {24'd0, m_data_o}, {24'd0, exp_e_data[c]});
            nextCycle();
        end

        // Seventeen back-to-back transfers: full throughput and counter wrap.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) pushWord(8'h80 + 8'(i));
        nextCycle();
        base_x = n_xfer;
        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (19) @(negedge clk_i);
        #1;
        checkOutput("f_nxfer", n_xfer - base_x, 32'd17);
        for (int i = 0; i < 17; i++) begin
            checkOutput($sformatf("f_order_%0d", i), {24'd0, xfer_log[base_x + i]}, 32'h80 + i);
        end
        checkOutput("f_count", {28'd0, m_count_o}, expCount(17));
        checkOutput("f_valid_end", {31'd0, m_valid_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
